btn_debounce: RTL and testbench

//   Front-end conditioner for a raw push-button feeding the stopwatch digit stage.
//   - Synchronises BTN_IN to CLK and filters contact bounce.
//   - Emits one single-cycle BTN_PULSE per debounced press; this drives the digit's BTN

---
 rtl/btn_debounce_pkg.sv | 22 ++
 rtl/btn_debounce_if.sv | 13 +
 rtl/btn_debounce_sync_2ff.sv | 21 ++
 rtl/btn_debounce.sv | 86 ++++++++
 tb/tb_btn_debounce.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioner: board debounce
// constant and FSM state encoding.
package btn_debounce_pkg;

    // Board-level debounce length in CLK cycles; board builds override this
    // to match the clock frequency (e.g. 2 ms worth of CLK).
    localparam int BOARD_DB_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PCHK = 2'd1,
        S_HELD = 2'd2,
        S_RCHK = 2'd3
    } db_state_t;

    // Debounced level is high while the button is accepted as pressed,
    // including the release-check window.
    function automatic logic level_of(input db_state_t s);
        return (s == S_HELD) || (s == S_RCHK);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button conditioner signal bundle: raw button in, pulse and level out.
interface btn_debounce_if;
    import btn_debounce_pkg::*;

    logic btn_in;
    logic btn_pulse;
    logic btn_level;

    // master drives the raw button and consumes the conditioned outputs
    modport master (output btn_in, input btn_pulse, input btn_level);
    // slave is the conditioner itself
    modport slave (input btn_in, output btn_pulse, output btn_level);
endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Generic 2-FF synchroniser (sync_2ff), reset to 0. Reusable for any
// single-bit asynchronous input.
module btn_debounce_sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic meta;

    // two-stage capture of the asynchronous input
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: synchronise, debounce, and emit one pulse per
// accepted press plus a debounced level.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DB_CYCLES = BOARD_DB_CYCLES
) (
    input  logic            CLK,
    input  logic            RST,
    btn_debounce_if.slave   bus
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    // With a one-cycle window the check states always resolve after a single
    // cycle, so even a one-cycle glitch on btn_s is accepted.
    localparam bit SHORT = (DB_CYCLES == 1);

    logic      btn_s;
    db_state_t state;
    logic [CW-1:0] cnt;
    logic      pulse_q;
    logic      level_q;

    btn_debounce_sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.btn_in),
        .q   (btn_s)
    );

    // debounce FSM with counter and registered pulse/level outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (btn_s) begin
                        state <= S_PCHK;
                        cnt   <= '0;
                    end
                end
                S_PCHK: begin
                    if (!btn_s && !SHORT) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state   <= S_HELD;
                        pulse_q <= 1'b1;
                        level_q <= level_of(S_HELD);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!btn_s) begin
                        state <= S_RCHK;
                        cnt   <= '0;
                    end
                end
                S_RCHK: begin
                    // bouncing back high returns to HELD without a new pulse
                    if (btn_s && !SHORT) begin
                        state <= S_HELD;
                    end else if (cnt == CNT_MAX) begin
                        state   <= S_IDLE;
                        level_q <= level_of(S_IDLE);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_pulse = pulse_q;
    assign bus.btn_level = level_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus pushes expected pulse cycles,
// per-DUT monitors pop and compare whenever a pulse appears.
module tb_btn_debounce;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   exp4_q[$];
    int   exp1_q[$];

    btn_debounce_if if4 ();
    btn_debounce_if if1 ();

    btn_debounce #(.DB_CYCLES(4)) dut (.CLK(CLK), .RST(RST), .bus(if4.slave));
    btn_debounce #(.DB_CYCLES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // pulse monitor, DB_CYCLES=4 instance
    always @(negedge CLK) begin
        if (if4.btn_pulse) begin
            int e;
            nvec++;
            if (exp4_q.size() == 0) begin
                nerr++;
                $display("FAIL pulse4_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = exp4_q.pop_front();
                if (e != cyc) begin
                    nerr++;
                    $display("FAIL pulse4_time: pulse at cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    // pulse monitor, DB_CYCLES=1 instance
    always @(negedge CLK) begin
        if (if1.btn_pulse) begin
            int e;
            nvec++;
            if (exp1_q.size() == 0) begin
                nerr++;
                $display("FAIL pulse1_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = exp1_q.pop_front();
                if (e != cyc) begin
                    nerr++;
                    $display("FAIL pulse1_time: pulse at cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp);
        end
    endtask

    initial begin
        int c;
        int r;
        int bnc[5];
        int rbn[4];
        bnc = '{1, 0, 1, 1, 0};
        rbn = '{0, 0, 1, 0};

        if4.btn_in = 1'b0;
        if1.btn_in = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_pulse4", if4.btn_pulse, 1'b0);
        chk("rst_level4", if4.btn_level, 1'b0);
        chk("rst_pulse1", if1.btn_pulse, 1'b0);
        chk("rst_level1", if1.btn_level, 1'b0);
        RST = 1'b0;
        repeat (3) tick();

        // 1. clean press held 20 cycles, then clean release
        c = cyc;
        if4.btn_in = 1'b1;
        exp4_q.push_back(c + 7);
        wait_cyc(c + 6);  chk("press_level_pre", if4.btn_level, 1'b0);
        wait_cyc(c + 7);  chk("press_level_on", if4.btn_level, 1'b1);
        wait_cyc(c + 20);
        r = cyc;
        if4.btn_in = 1'b0;
        wait_cyc(r + 6);  chk("rel_level_pre", if4.btn_level, 1'b1);
        wait_cyc(r + 7);  chk("rel_level_off", if4.btn_level, 1'b0);
        repeat (4) tick();

        // 2. press bounce 1,0,1,1,0 then 1 held; stable run sampled from c+6
        c = cyc;
        for (int i = 0; i < 5; i++) begin
            if4.btn_in = bnc[i][0];
            tick();
        end
        if4.btn_in = 1'b1;
        exp4_q.push_back(c + 12);
        wait_cyc(c + 11); chk("bounce_level_pre", if4.btn_level, 1'b0);
        wait_cyc(c + 12); chk("bounce_level_on", if4.btn_level, 1'b1);
        repeat (5) tick();

        // 3. release bounce 0,0,1,0 then 0 held; stable-0 run sampled from r+4
        r = cyc;
        for (int i = 0; i < 4; i++) begin
            if4.btn_in = rbn[i][0];
            tick();
        end
        if4.btn_in = 1'b0;
        wait_cyc(r + 9);  chk("rbounce_level_pre", if4.btn_level, 1'b1);
        wait_cyc(r + 10); chk("rbounce_level_off", if4.btn_level, 1'b0);
        repeat (4) tick();

        // 4. reset while in S_PCHK with cnt=2, button kept held
        c = cyc;
        if4.btn_in = 1'b1;
        wait_cyc(c + 5);
        RST = 1'b1;
        wait_cyc(c + 6);
        chk("midrst_pulse_a", if4.btn_pulse, 1'b0);
        chk("midrst_level_a", if4.btn_level, 1'b0);
        wait_cyc(c + 7);
        chk("midrst_pulse_b", if4.btn_pulse, 1'b0);
        chk("midrst_level_b", if4.btn_level, 1'b0);
        RST = 1'b0;
        exp4_q.push_back(c + 14);
        wait_cyc(c + 13); chk("midrst_level_pre", if4.btn_level, 1'b0);
        wait_cyc(c + 14); chk("midrst_level_on", if4.btn_level, 1'b1);
        repeat (4) tick();
        if4.btn_in = 1'b0;
        repeat (10) tick();

        // 5. three presses of 10 high / 10 low
        for (int p = 0; p < 3; p++) begin
            c = cyc;
            if4.btn_in = 1'b1;
            exp4_q.push_back(c + 7);
            wait_cyc(c + 8);  chk("rep_pulse_width", if4.btn_pulse, 1'b0);
            wait_cyc(c + 10);
            if4.btn_in = 1'b0;
            wait_cyc(c + 20);
            chk("rep_level_off", if4.btn_level, 1'b0);
        end

        // 6. DB_CYCLES=1: one-cycle high on the raw input
        c = cyc;
        if1.btn_in = 1'b1;
        exp1_q.push_back(c + 4);
        tick();
        if1.btn_in = 1'b0;
        wait_cyc(c + 3);  chk("db1_level_pre", if1.btn_level, 1'b0);
        wait_cyc(c + 4);  chk("db1_level_a", if1.btn_level, 1'b1);
        wait_cyc(c + 5);  chk("db1_level_b", if1.btn_level, 1'b1);
        wait_cyc(c + 6);  chk("db1_level_off", if1.btn_level, 1'b0);

        repeat (10) tick();
        nvec++;
        if (exp4_q.size() != 0) begin
            nerr++;
            $display("FAIL pulse4_missing: %0d expected pulses never seen, expected 0", exp4_q.size());
        end
        nvec++;
        if (exp1_q.size() != 0) begin
            nerr++;
            $display("FAIL pulse1_missing: %0d expected pulses never seen, expected 0", exp1_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
